fifo_wr_arb: RTL
================

# fifo_wr_arb

Two-requester write-side arbiter for the 8-entry FIFO. It shares the FIFO's single write port between two producers, `req0` and `req1`, using round-robin priority. It never issues a write the FIFO cannot accept: admission is gated on the FIFO's `data_count` plus any write already in flight, so the FIFO's write-error path is never exercised. The block sits directly in front of the FIFO's `wr_en` and `din` inputs, and its registered outputs feed them.

## Interface
- `DATA_WIDTH`, 32, width of requester data and FIFO data
- `DEPTH`, 8, FIFO capacity in words
- `CNT_WIDTH`, 4, width of `fifo_data_count` (holds 0..`DEPTH`)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  write request; held high until the matching `ack`
- `din0`, `din1`  in  `DATA_WIDTH`  requester data; stable while `req` is high
- `ack0`, `ack1`  out  1  one-cycle pulse; the requester's word is on `fifo_din` this cycle
- `fifo_wr_en`  out  1  FIFO write enable, registered
- `fifo_din`  out  `DATA_WIDTH`  FIFO write data, registered
- `fifo_data_count`  in  `CNT_WIDTH`  current FIFO occupancy
- `stall`  out  1  high in `ST_STALL` (requests pending, no space)

## Operation
- Decision is made each cycle from the same-cycle `req*`, `fifo_data_count`, the current `fifo_wr_en`, the current `ack*` and the priority pointer `last`. The decision's results are registered.
- `space_ok` = (`fifo_data_count` + `fifo_wr_en`) < `DEPTH`. Compute the sum at `CNT_WIDTH`+1 bits to avoid overflow at `DEPTH`.
- Effective request: `ereq_i` = `req_i` & ~`ack_i`. A requester being acked this cycle is masked, so stale data is never re-sampled.
- Each requester can therefore be granted at most once every 2 cycles. With both requesters active, grants alternate and the block issues one write per cycle.
- Winner when both `ereq` are high: the requester other than `last`. When only one `ereq` is high, that requester wins.
- On a grant at edge t:
  - `fifo_wr_en` goes to 1 and `fifo_din` takes the winner's `din`.
  - The winner's `ack` goes to 1.
  - `last` takes the winner.
  - All three are visible in cycle t+1.
- With no grant, `fifo_wr_en` and both `ack` outputs go to 0, and `fifo_din` holds its value.
- FSM states, encoded as a 2-bit binary state:
  - `ST_IDLE`: no `ereq` is high.
  - `ST_WR0`: grant to requester 0 this edge.
  - `ST_WR1`: grant to requester 1 this edge.
  - `ST_STALL`: some `ereq` is high but `space_ok` is 0.
- Next state is purely a function of the decision inputs above. Any state may go to any state.
- Only `ST_WR*` produce a write. `stall` is 1 exactly while the state is `ST_STALL`.
- Illegal state encoding recovers to `ST_IDLE` on the next edge.

## Timing
- Reset, synchronous and sampled on the rising edge:
  - state = `ST_IDLE`, `last` = 1 (requester 0 wins first).
  - `fifo_wr_en` = 0, `fifo_din` = 0, `ack0` = `ack1` = 0, `stall` = 0.
  - Counters, if compiled in, = 0.
- Reset asserted mid-write drops `fifo_wr_en` and `ack` on the next edge. An in-flight requester never sees an ack for that word and must keep `req` high.
- Latency: `req` high in cycle t with space available gives `ack` and `fifo_wr_en` in cycle t+1.
- Full boundary:
  - `fifo_data_count` = 7 with `fifo_wr_en` = 1 means no grant (STALL).
  - `fifo_data_count` = 7 with `fifo_wr_en` = 0 allows one grant.
- Requester handshake: the requester sees `ack` in cycle t+1. It may update `din` or drop `req` at the end of cycle t+1. Dropping `req` before `ack` is illegal.

## Configuration
- `FIFO_ARB_STAT_EN`, when defined:
  - Adds outputs `gnt_cnt0` and `gnt_cnt1` (out, 8 bits each), counting acks per requester.
  - Adds output `stall_cnt` (out, 8 bits), counting cycles spent in `ST_STALL`.
  - All three saturate at 255 and clear on `reset`.
- When undefined, these ports and registers do not exist, and the arbitration behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - `ST_IDLE`/`ST_WR0`/`ST_WR1`/`ST_STALL` encodings (00/01/10/11).
  - `FIFO_DEPTH` = 8 and `FIFO_CNT_WIDTH` = 4, also used by the FIFO itself.
- One sub-module `fifo_arb_ns`: combinational next-state, winner and `space_ok` logic. The top holds the state, `last`, output and counter registers.

## Test plan
- Reset, then `req0` = 1 with `din0` = 0xA5 and count 0: cycle t+1 shows `ack0` = 1, `fifo_wr_en` = 1, `fifo_din` = 0xA5. `ack1` stays 0.
- Both requests held continuously with count 0: writes every cycle, acks alternate 0,1,0,1.
- Back-to-back single requester (`req0` held, new `din0` after each ack): a write every other cycle, never the same word twice.
- Count 6, both requesting, no reads: exactly two writes (count reaches 8), then `stall` = 1 and no `fifo_wr_en`. Drive count down to 7 and one write is issued.
- Count 7 with a write in flight: no grant that cycle. `stall` = 1.
- `reset` during a write burst: next cycle all outputs are 0 and the state is `ST_IDLE`. After release with both requesting, `ack0` comes first. With `FIFO_ARB_STAT_EN`, counters read 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and arbiter state encoding for the 8-entry FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int FIFO_DEPTH     = 8;
    localparam int FIFO_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WR0   = 2'b01,
        ST_WR1   = 2'b10,
        ST_STALL = 2'b11
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_arb_ns.sv
// ============================================================================
// Module      : fifo_arb_ns
// Description : Combinational next-state, round-robin winner and space check.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_arb_ns
    import fifo_pkg::*;
#(
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int CNT_WIDTH = FIFO_CNT_WIDTH
) (
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic                 i_ack0,
    input  logic                 i_ack1,
    input  logic                 i_wr_en,
    input  logic [CNT_WIDTH-1:0] i_data_count,
    input  logic                 i_last,
    output arb_state_t           o_next_state
);

    localparam logic [CNT_WIDTH:0] c_DEPTH = (CNT_WIDTH+1)'(DEPTH);

    logic [CNT_WIDTH:0] w_occupancy;
    logic               w_space_ok;
    logic               w_ereq0;
    logic               w_ereq1;

    // Occupancy includes the write already on the FIFO's input this cycle.
    assign w_occupancy = {1'b0, i_data_count} + {{CNT_WIDTH{1'b0}}, i_wr_en};
    assign w_space_ok  = (w_occupancy < c_DEPTH);

    // A requester being acked now still shows its old word; mask it.
    assign w_ereq0 = i_req0 & ~i_ack0;
    assign w_ereq1 = i_req1 & ~i_ack1;

    always_comb begin
        o_next_state = ST_IDLE;
        if (w_ereq0 || w_ereq1) begin
            if (!w_space_ok) begin
                o_next_state = ST_STALL;
            end else if (w_ereq0 && w_ereq1) begin
                o_next_state = i_last ? ST_WR0 : ST_WR1;
            end else if (w_ereq0) begin
                o_next_state = ST_WR0;
            end else begin
                o_next_state = ST_WR1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arb.sv
// ============================================================================
// Module      : fifo_wr_arb
// Description : Two-requester round-robin arbiter for the FIFO write port.
//               Optional statistics counters enabled by FIFO_ARB_STAT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic [CNT_WIDTH-1:0]  fifo_data_count,
    output logic                  stall
`ifdef FIFO_ARB_STAT_EN
    ,
    output logic [7:0]            gnt_cnt0,
    output logic [7:0]            gnt_cnt1,
    output logic [7:0]            stall_cnt
`endif
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  r_last;
    logic                  r_wr_en;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [DATA_WIDTH-1:0] r_din;

    fifo_arb_ns #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ns (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_ack0       (r_ack0),
        .i_ack1       (r_ack1),
        .i_wr_en      (r_wr_en),
        .i_data_count (fifo_data_count),
        .i_last       (r_last),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_last = 1 after reset so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_wr_en <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_din   <= '0;
        end else begin
            r_wr_en <= (w_next_state == ST_WR0) || (w_next_state == ST_WR1);
            r_ack0  <= (w_next_state == ST_WR0);
            r_ack1  <= (w_next_state == ST_WR1);
            if (w_next_state == ST_WR0) begin
                r_din  <= din0;
                r_last <= 1'b0;
            end else if (w_next_state == ST_WR1) begin
                r_din  <= din1;
                r_last <= 1'b1;
            end
        end
    end

    assign fifo_wr_en = r_wr_en;
    assign fifo_din   = r_din;
    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign stall      = (r_state == ST_STALL);

`ifdef FIFO_ARB_STAT_EN
    logic [7:0] r_gnt_cnt0;
    logic [7:0] r_gnt_cnt1;
    logic [7:0] r_stall_cnt;

    // Saturating counters; each increments on a cycle its event is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_cnt0  <= '0;
            r_gnt_cnt1  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_ack0 && (r_gnt_cnt0 != 8'hFF)) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + 8'd1;
            end
            if (r_ack1 && (r_gnt_cnt1 != 8'hFF)) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + 8'd1;
            end
            if ((r_state == ST_STALL) && (r_stall_cnt != 8'hFF)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end
    end

    assign gnt_cnt0  = r_gnt_cnt0;
    assign gnt_cnt1  = r_gnt_cnt1;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
